draw_map_scroll: RTL and testbench
==================================

# draw_map_scroll

Parametrised background map renderer with horizontal scrolling, integer pixel scaling, colour-key transparency and a configurable ROM latency. It sits in the VGA chain between the timing/background stage and the sprite stages. It consumes one `vga_if` stream and emits a delayed copy in which pixels inside the map window come from an external map ROM. The scroll position is updated only at frame boundaries, so a frame never shows a tear.

## Interface
Parameters:
- `XPOS`, default 0: window left edge, screen pixels.
- `YPOS`, default 0: window top edge, screen pixels.
- `SCALE_LOG2`, default 2: each texel is 2^SCALE_LOG2 × 2^SCALE_LOG2 screen pixels.
- `MAP_W`, default 256: map width in texels; power of 2; COL_W = log2(MAP_W).
- `MAP_H`, default 64: map height in texels; power of 2; ROW_W = log2(MAP_H).
- `WIN_W`, default 1024: window width, screen pixels. Window height is MAP_H << SCALE_LOG2.
- `ROM_LAT`, default 1: cycles from `pixel_adr` registered to `rgb_pixel` valid; ≥ 0.
- `KEY_EN`, default 0: 1 enables transparency.
- `KEY_RGB`, default 12'hF0F: transparent colour.

Ports:
- `clk`, in, 1: pixel clock; the single clock of the block.
- `rst`, in, 1: reset; synchronous, active-high.
- `in`, vga_if.in: upstream timing and rgb.
- `out`, vga_if.out: downstream timing and rgb.
- `scroll_mode`, in, 1: 0 = load `scroll_x` each frame; 1 = auto-increment each frame.
- `scroll_x`, in, COL_W: scroll target in texels (mode 0).
- `scroll_step`, in, COL_W: per-frame increment in texels (mode 1).
- `rgb_pixel`, in, 12: ROM data.
- `pixel_adr`, out, ROW_W+COL_W: ROM address {row, col}.

## Operation
- Scroll register `scroll_q` (COL_W bits):
  - Updates only on the cycle where `in.vblnk` rises (`vblnk_q`=0, `in.vblnk`=1).
  - Mode 0: `scroll_q` ← `scroll_x`.
  - Mode 1: `scroll_q` ← `scroll_q + scroll_step`, truncated to COL_W bits.
  - Input changes between edges are ignored.
- Address, computed combinationally from the `in` counts:
  - col = ((`in.hcount` − XPOS) >> SCALE_LOG2) + `scroll_q`, truncated to COL_W bits. Truncation gives the horizontal wrap.
  - row = (`in.vcount` − YPOS) >> SCALE_LOG2, truncated to ROW_W bits.
  - `pixel_adr` is registered every cycle, inside or outside the window.
- Window hit at stage 0: XPOS ≤ hcount < XPOS+WIN_W, YPOS ≤ vcount < YPOS+(MAP_H<<SCALE_LOG2), and `in.hblnk`=0 and `in.vblnk`=0. The hit flag is piped with the data.
- Output select at the last stage:
  - hit && !(KEY_EN && `rgb_pixel`==KEY_RGB) → `rgb_pixel`.
  - Otherwise → delayed `in.rgb`.
- The map never wraps vertically. Rows outside the window are not drawn.

## Timing
- Latency L = ROM_LAT + 2 cycles. This applies to every `out` field (hcount, vcount, hsync, vsync, hblnk, vblnk, rgb) relative to `in`.
- `pixel_adr` is registered 1 cycle after `in`. `rgb_pixel` is sampled ROM_LAT cycles later. `out.rgb` is registered 1 cycle after that.
- Reset: all `out` fields = 0, `pixel_adr` = 0, `scroll_q` = 0, `vblnk_q` = 0, all pipeline stages = 0.
- For L cycles after `rst` deasserts, `out` carries the zeroed pipeline contents.
- Reset asserted mid-frame: same as above. Scroll restarts at 0 and the next vblnk edge applies normally.
- `rst` and a vblnk edge in the same cycle: reset wins and `scroll_q` = 0.
- Mode change takes effect at the next vblnk edge.
- `scroll_q` increment overflow wraps modulo MAP_W.

## Structure
- `vga_pkg` holds the shared constants: HOR_PIXELS, VER_PIXELS, RGB width.
- New `map_pkg` holds:
  - `map_adr_t` (packed struct {row, col}).
  - Scroll mode enum `SCROLL_LOAD`/`SCROLL_AUTO`.
- Sub-module `vga_delay #(DEPTH)` delays the `vga_if` timing fields plus rgb and hit. It is reused for the ROM_LAT alignment.
- The top level holds the scroll register, edge detect, address arithmetic and output mux.

## Test plan
- Defaults, mode 0, `scroll_x`=0, ROM data = address: at hcount=8, vcount=4 → `pixel_adr`={1,2} 1 cycle later; `out.rgb`=ROM word 3 cycles later.
- `scroll_x`=250 written mid-frame → no change in that frame. Next frame: hcount=40 gives col=(10+250) mod 256=4.
- Mode 1, `scroll_step`=3 over 100 frames → `scroll_q`=300 mod 256=44. Column wrap from 255 to 0 is seamless on screen.
- KEY_EN=1, ROM returns 12'hF0F at a window pixel → `out.rgb` = `in.rgb` delayed 3 cycles. ROM returns 12'h0F0 → `out.rgb`=12'h0F0.
- vcount=256 (below window) or hblnk=1 → `out.rgb` = delayed `in.rgb`. Sync and blank outputs always equal `in` delayed exactly L cycles. Repeat with ROM_LAT=0 (L=2) and ROM_LAT=3 (L=5).
- Assert `rst` for 1 cycle mid-line → next cycle all outputs 0 and `scroll_q`=0. Outputs are zero for L cycles, then they track `in`.

Source files
------------

// File: rtl/map_pkg.sv
// map_pkg: map ROM address layout and scroll modes.
//   map_adr_t     : {row, col} ROM address for the default 256x64 texel map
//   scroll_mode_e : LOAD takes scroll_x each frame, AUTO adds scroll_step
package map_pkg;

    localparam int MAP_COL_W = 8;
    localparam int MAP_ROW_W = 6;

    typedef struct packed {
        logic [MAP_ROW_W-1:0] row;
        logic [MAP_COL_W-1:0] col;
    } map_adr_t;

    typedef enum logic {
        SCROLL_LOAD = 1'b0,
        SCROLL_AUTO = 1'b1
    } scroll_mode_e;

endpackage

// File: rtl/vga_pkg.sv
// vga_pkg: constants and the flattened pixel record shared by every stage
// of the VGA chain.
//   HOR_PIXELS/VER_PIXELS : visible resolution of the timing generator
//   CNT_W                 : width of hcount/vcount
//   RGB_W                 : 4:4:4 colour word width
//   vga_t                 : all vga_if fields packed into one word, so they
//                           can travel through a delay line together
package vga_pkg;

    localparam int HOR_PIXELS = 1024;
    localparam int VER_PIXELS = 768;
    localparam int CNT_W      = 11;
    localparam int RGB_W      = 12;

    typedef struct packed {
        logic [CNT_W-1:0] hcount;
        logic [CNT_W-1:0] vcount;
        logic             hsync;
        logic             vsync;
        logic             hblnk;
        logic             vblnk;
        logic [RGB_W-1:0] rgb;
    } vga_t;

endpackage

// File: rtl/vga_if.sv
// vga_if: one VGA stream (timing counts, syncs, blanks, rgb).
//   modport in  : consumer side (all fields are inputs)
//   modport out : producer side (all fields are outputs)
interface vga_if;
    import vga_pkg::*;

    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/vga_delay.sv
// vga_delay: DEPTH-stage delay line for a VGA pixel record plus its window
// hit flag. Every stage clears on reset, so a freshly reset chain emits
// zeros until real pixels have worked their way through.
//   clk, rst : pixel clock, synchronous active-high reset
//   d, d_hit : pixel record and hit flag entering the line
//   q, q_hit : the same, DEPTH cycles later (DEPTH >= 1)
module vga_delay
    import vga_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  vga_t d,
    input  logic d_hit,
    output vga_t q,
    output logic q_hit
);

    vga_t             pipe     [DEPTH];
    logic [DEPTH-1:0] hit_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
            hit_pipe <= '0;
        end else begin
            pipe[0]     <= d;
            hit_pipe[0] <= d_hit;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i]     <= pipe[i-1];
                hit_pipe[i] <= hit_pipe[i-1];
            end
        end
    end

    assign q     = pipe[DEPTH-1];
    assign q_hit = hit_pipe[DEPTH-1];

endmodule

// File: rtl/draw_map_scroll.sv
// draw_map_scroll: overlays a horizontally scrolling, integer-scaled texel
// map onto a VGA stream. Total latency is ROM_LAT + 2 for every out field.
//   clk, rst      : pixel clock, synchronous active-high reset
//   in, out       : upstream / downstream VGA stream
//   scroll_mode   : 0 = load scroll_x per frame, 1 = add scroll_step per frame
//   scroll_x      : scroll target in texels
//   scroll_step   : per-frame increment in texels
//   rgb_pixel     : map ROM data, valid ROM_LAT cycles after pixel_adr
//   pixel_adr     : registered map ROM address {row, col}
module draw_map_scroll
    import vga_pkg::*;
    import map_pkg::*;
#(
    parameter int         XPOS       = 0,
    parameter int         YPOS       = 0,
    parameter int         SCALE_LOG2 = 2,
    parameter int         MAP_W      = 256,
    parameter int         MAP_H      = 64,
    parameter int         WIN_W      = 1024,
    parameter int         ROM_LAT    = 1,
    parameter bit         KEY_EN     = 1'b0,
    parameter logic [11:0] KEY_RGB   = 12'hF0F,
    localparam int        COL_W      = $clog2(MAP_W),
    localparam int        ROW_W      = $clog2(MAP_H)
) (
    input  logic                   clk,
    input  logic                   rst,
    vga_if.in                      in,
    vga_if.out                     out,
    input  logic                   scroll_mode,
    input  logic [COL_W-1:0]       scroll_x,
    input  logic [COL_W-1:0]       scroll_step,
    input  logic [RGB_W-1:0]       rgb_pixel,
    output logic [ROW_W+COL_W-1:0] pixel_adr
);

    localparam int WIN_H = MAP_H << SCALE_LOG2;

    vga_t             in_v, dly_v, out_d, out_q;
    logic             in_hit, dly_hit, use_map;
    logic             vblnk_q, vblnk_rise;
    logic [COL_W-1:0] scroll_q, col;
    logic [ROW_W-1:0] row;
    logic [CNT_W-1:0] hrel, vrel;

    assign in_v = {in.hcount, in.vcount, in.hsync, in.vsync,
                   in.hblnk, in.vblnk, in.rgb};

    // Scroll only moves on the vblnk rising edge so a frame never tears.
    assign vblnk_rise = in.vblnk & ~vblnk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_q  <= 1'b0;
            scroll_q <= '0;
        end else begin
            vblnk_q <= in.vblnk;
            if (vblnk_rise)
                scroll_q <= (scroll_mode == SCROLL_AUTO) ? scroll_q + scroll_step
                                                         : scroll_x;
        end
    end

    // Truncating col to COL_W bits is what wraps the map horizontally.
    // Outside the window the address is still produced; the hit flag keeps
    // it from reaching the screen.
    assign hrel = in.hcount - CNT_W'(XPOS);
    assign vrel = in.vcount - CNT_W'(YPOS);
    assign col  = COL_W'(hrel >> SCALE_LOG2) + scroll_q;
    assign row  = ROW_W'(vrel >> SCALE_LOG2);

    assign in_hit = (32'(in.hcount) >= 32'(XPOS)) && (32'(in.hcount) < 32'(XPOS + WIN_W)) &&
                    (32'(in.vcount) >= 32'(YPOS)) && (32'(in.vcount) < 32'(YPOS + WIN_H)) &&
                    !in.hblnk && !in.vblnk;

    always_ff @(posedge clk) begin
        if (rst) pixel_adr <= '0;
        else     pixel_adr <= {row, col};
    end

    // One stage matching the address register plus ROM_LAT stages matching
    // the ROM, so dly_v lines up with rgb_pixel.
    vga_delay #(.DEPTH(ROM_LAT + 1)) u_delay (
        .clk   (clk),
        .rst   (rst),
        .d     (in_v),
        .d_hit (in_hit),
        .q     (dly_v),
        .q_hit (dly_hit)
    );

    assign use_map = dly_hit && !(KEY_EN && (rgb_pixel == KEY_RGB));

    always_comb begin
        out_d = dly_v;
        if (use_map) out_d.rgb = rgb_pixel;
    end

    always_ff @(posedge clk) begin
        if (rst) out_q <= '0;
        else     out_q <= out_d;
    end

    assign out.hcount = out_q.hcount;
    assign out.vcount = out_q.vcount;
    assign out.hsync  = out_q.hsync;
    assign out.vsync  = out_q.vsync;
    assign out.hblnk  = out_q.hblnk;
    assign out.vblnk  = out_q.vblnk;
    assign out.rgb    = out_q.rgb;

endmodule

// File: tb/tb_draw_map_scroll.sv
// tb_draw_map_scroll: three instances (ROM_LAT 1 with colour key, ROM_LAT 0
// with an offset half-size window, ROM_LAT 3 plain) share one random input
// stream; each is compared every cycle against a per-pixel reference model.
module tb_draw_map_scroll;
    import vga_pkg::*;

    localparam int ND = 3;

    typedef struct {
        int xp, yp, sc, mw, mh, ww, lat;
        bit key;
    } cfg_t;

    function automatic cfg_t cfg_of(int d);
        cfg_t c;
        case (d)
            0:       c = '{xp:0,  yp:0, sc:2, mw:256, mh:64, ww:1024, lat:1, key:1'b1};
            1:       c = '{xp:16, yp:8, sc:1, mw:128, mh:32, ww:512,  lat:0, key:1'b0};
            default: c = '{xp:0,  yp:0, sc:2, mw:256, mh:64, ww:1024, lat:3, key:1'b0};
        endcase
        return c;
    endfunction

    // External ROM contents: every 7th word is the key colour.
    function automatic logic [11:0] rom(int a);
        if (a % 7 == 3) return 12'hF0F;
        return 12'(a * 37 + 5);
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [7:0]  sx, sst;
    logic [11:0] rgb_pix [ND];
    logic [13:0] adr0, adr2;
    logic [11:0] adr1;
    logic [31:0] adr_o [ND];
    logic [37:0] out_o [ND];
    logic [11:0] rom_sr [ND][4];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_if vin();
    vga_if vo0();
    vga_if vo1();
    vga_if vo2();

    draw_map_scroll #(.KEY_EN(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in(vin), .out(vo0), .scroll_mode(mode),
        .scroll_x(sx), .scroll_step(sst), .rgb_pixel(rgb_pix[0]), .pixel_adr(adr0));

    draw_map_scroll #(.XPOS(16), .YPOS(8), .SCALE_LOG2(1), .MAP_W(128), .MAP_H(32),
                      .WIN_W(512), .ROM_LAT(0)) dut1 (
        .clk(clk), .rst(rst), .in(vin), .out(vo1), .scroll_mode(mode),
        .scroll_x(sx[6:0]), .scroll_step(sst[6:0]), .rgb_pixel(rgb_pix[1]), .pixel_adr(adr1));

    draw_map_scroll #(.ROM_LAT(3)) dut2 (
        .clk(clk), .rst(rst), .in(vin), .out(vo2), .scroll_mode(mode),
        .scroll_x(sx), .scroll_step(sst), .rgb_pixel(rgb_pix[2]), .pixel_adr(adr2));

    always_comb begin
        adr_o[0] = 32'(adr0);
        adr_o[1] = 32'(adr1);
        adr_o[2] = 32'(adr2);
        out_o[0] = {vo0.hcount, vo0.vcount, vo0.hsync, vo0.vsync, vo0.hblnk, vo0.vblnk, vo0.rgb};
        out_o[1] = {vo1.hcount, vo1.vcount, vo1.hsync, vo1.vsync, vo1.hblnk, vo1.vblnk, vo1.rgb};
        out_o[2] = {vo2.hcount, vo2.vcount, vo2.hsync, vo2.vsync, vo2.hblnk, vo2.vblnk, vo2.rgb};
    end

    // ROM with a per-instance read latency.
    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            rom_sr[d][0] <= rom(int'(adr_o[d]));
            for (int i = 1; i < 4; i++) rom_sr[d][i] <= rom_sr[d][i-1];
        end
    end

    always_comb begin
        for (int d = 0; d < ND; d++)
            rgb_pix[d] = (cfg_of(d).lat == 0) ? rom(int'(adr_o[d])) : rom_sr[d][cfg_of(d).lat - 1];
    end

    // Reference model: hist[d][k] is the output expected k cycles after the
    // pixel was presented; exp_adr is the address of the latest pixel.
    logic [37:0] hist [ND][8];
    int          exp_adr [ND];
    int          scr [ND];
    bit          pvb;

    task automatic model_edge();
        for (int d = 0; d < ND; d++) begin
            cfg_t c = cfg_of(d);
            if (rst) begin
                for (int k = 0; k < 8; k++) hist[d][k] = '0;
                scr[d]     = 0;
                exp_adr[d] = 0;
            end else begin
                int hc = int'(vin.hcount);
                int vc = int'(vin.vcount);
                int col = (((hc - c.xp) >>> c.sc) + scr[d]) & (c.mw - 1);
                int row = ((vc - c.yp) >>> c.sc) & (c.mh - 1);
                int a = row * c.mw + col;
                bit hit = hc >= c.xp && hc < c.xp + c.ww && vc >= c.yp &&
                          vc < c.yp + (c.mh << c.sc) && !vin.hblnk && !vin.vblnk;
                logic [11:0] px = (hit && !(c.key && rom(a) == 12'hF0F)) ? rom(a) : vin.rgb;
                for (int k = 7; k > 0; k--) hist[d][k] = hist[d][k-1];
                hist[d][0] = {vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk, px};
                exp_adr[d] = a;
                if (vin.vblnk && !pvb)
                    scr[d] = mode ? (scr[d] + int'(sst)) & (c.mw - 1) : int'(sx) & (c.mw - 1);
            end
        end
        pvb = rst ? 1'b0 : vin.vblnk;
    endtask

    task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("out%0d", d), 64'(out_o[d]), 64'(hist[d][cfg_of(d).lat + 1]));
            check($sformatf("adr%0d", d), 64'(adr_o[d]), 64'(exp_adr[d]));
        end
    endtask

    task automatic drive(int hc, int vc, bit hb, bit vb);
        vin.hcount = 11'(hc);
        vin.vcount = 11'(vc);
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.hsync  = 1'($urandom);
        vin.vsync  = 1'($urandom);
        vin.rgb    = 12'($urandom);
    endtask

    task automatic rand_pix();
        int hc = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 1100) : $urandom_range(0, 1343);
        int vc = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 300)  : $urandom_range(0, 805);
        drive(hc, vc, $urandom_range(0, 7) == 0, 1'b0);
        tick();
    endtask

    // n active pixels (scroll_x changes mid-frame), then two vblnk cycles.
    task automatic frame(int n);
        for (int i = 0; i < n; i++) begin
            if (i == n / 2) sx = 8'($urandom);
            rand_pix();
        end
        repeat (2) begin
            drive($urandom_range(0, 1343), $urandom_range(0, 805), 1'b1, 1'b1);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; sx = 8'd0; sst = 8'd0;
        pvb = 1'b0;
        // vblnk high through reset: the first post-reset cycle is an edge
        drive(0, 0, 1'b1, 1'b1);
        repeat (3) tick();
        for (int d = 0; d < ND; d++) check("reset_out", 64'(out_o[d]), 64'd0);
        check("reset_adr", 64'(adr0), 64'd0);
        rst = 1'b0;
        tick();

        // scroll 0: hcount 8, vcount 4 -> row 1, col 2
        drive(8, 4, 1'b0, 1'b0);
        tick();
        check("adr_8_4", 64'(adr0), 64'h102);
        repeat (4) rand_pix();

        repeat (30) frame(20);

        // mid-frame scroll_x write only lands at the next vblnk edge
        drive(0, 0, 1'b0, 1'b0); tick();
        sx = 8'd0;
        drive(0, 0, 1'b1, 1'b1); tick();
        drive(40, 0, 1'b0, 1'b0); tick();
        check("col_scroll0", 64'(adr0), 64'd10);
        sx = 8'd250;
        drive(40, 0, 1'b0, 1'b0); tick();
        check("col_midframe", 64'(adr0), 64'd10);
        drive(0, 0, 1'b1, 1'b1); tick();
        drive(40, 0, 1'b0, 1'b0); tick();
        check("col_wrap250", 64'(adr0), 64'd4);

        // one-cycle reset mid-line, then auto scroll by 3 for 100 frames
        drive(500, 100, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        for (int d = 0; d < ND; d++) check("midline_rst", 64'(out_o[d]), 64'd0);
        check("midline_rst_adr", 64'(adr0), 64'd0);
        rst = 1'b0; mode = 1'b1; sst = 8'd3;
        repeat (100) frame(3);
        drive(0, 0, 1'b0, 1'b0); tick();
        check("auto_scroll44", 64'(adr0), 64'd44);

        // key colour at col 3 passes the input rgb; col 4 shows the map
        drive(860, 0, 1'b0, 1'b0); vin.rgb = 12'h123; tick();
        drive(864, 0, 1'b0, 1'b0); tick();
        drive(0, 300, 1'b0, 1'b0); tick();
        check("key_pass", 64'(vo0.rgb), 64'h123);
        drive(0, 300, 1'b0, 1'b0); tick();
        check("key_map", 64'(vo0.rgb), 64'h099);

        repeat (40) begin
            mode = 1'($urandom);
            sst  = 8'($urandom);
            frame(12);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
